csi_decoder: RTL and testbench

CSI_DECODER -- requirements
Module: csi_decoder

---
 rtl/csi_pkg.sv | 80 ++++++++
 rtl/csi_decoder_if.sv | 29 ++
 rtl/csi_param_acc.sv | 39 +++
 rtl/csi_decoder.sv | 172 +++++++++++++++++
 tb/tb_csi_decoder.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csi_pkg.sv
// Shared command/state types and byte constants for the CSI decoder.
// CSI_TEXT_CMD_EN adds the TEXT state used for typed-word commands.
package csi_pkg;

    typedef enum logic [4:0] {
        CMD_NONE,
        CMD_UNKNOWN,
        CMD_CUU,
        CMD_CUD,
        CMD_CUF,
        CMD_CUB,
        CMD_CNL,
        CMD_CPL,
        CMD_CHA,
        CMD_CUP,
        CMD_ED,
        CMD_EL,
        CMD_SU,
        CMD_SD,
        CMD_HVP,
        CMD_SCP,
        CMD_RCP,
        CMD_DEL,
        CMD_CLEAR,
        CMD_UNAME
    } cmd_e;

`ifdef CSI_TEXT_CMD_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_ESC, ST_CSI, ST_TEXT
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_ESC, ST_CSI
    } state_e;
`endif

    localparam logic [7:0] B_ESC   = 8'h1B;
    localparam logic [7:0] B_CSI   = 8'h5B;
    localparam logic [7:0] B_SEP   = 8'h3B;
    localparam logic [7:0] B_TILDE = 8'h7E;

    localparam logic [39:0] TXT_CLEAR = "clear";
    localparam logic [63:0] TXT_UNAME = "uname -a";

    function automatic cmd_e final_cmd(
        input logic [7:0] b,
        input logic       p0_is3
    );
        cmd_e c;
        case (b)
            8'h41:   c = CMD_CUU;
            8'h42:   c = CMD_CUD;
            8'h43:   c = CMD_CUF;
            8'h44:   c = CMD_CUB;
            8'h45:   c = CMD_CNL;
            8'h46:   c = CMD_CPL;
            8'h47:   c = CMD_CHA;
            8'h48:   c = CMD_CUP;
            8'h4A:   c = CMD_ED;
            8'h4B:   c = CMD_EL;
            8'h53:   c = CMD_SU;
            8'h54:   c = CMD_SD;
            8'h66:   c = CMD_HVP;
            8'h73:   c = CMD_SCP;
            8'h75:   c = CMD_RCP;
            B_TILDE: c = p0_is3 ? CMD_DEL : CMD_UNKNOWN;
            default: c = CMD_UNKNOWN;
        endcase
        return c;
    endfunction

    // Cursor-motion style commands treat an omitted count as 1.
    function automatic logic dflt_one(input cmd_e c);
        return c inside {CMD_CUU, CMD_CUD, CMD_CUF, CMD_CUB,
                         CMD_CNL, CMD_CPL, CMD_CHA, CMD_CUP,
                         CMD_HVP, CMD_SU, CMD_SD};
    endfunction

endpackage

// File: rtl/csi_decoder_if.sv
// Byte-in / command-out bundle of the CSI decoder.
// master drives bytes, slave is the decoder.
interface csi_decoder_if
    import csi_pkg::*;
#(
    parameter int NPARAM = 2,
    parameter int PW     = 8
);
    logic [7:0]           in;
    logic                 in_valid;
    logic                 cmd_valid;
    cmd_e                 cmd_code;
    logic [NPARAM*PW-1:0] params;
    logic [2:0]           nparams;
    logic                 err;
    logic [2:0]           state;

    modport master (
        output in, in_valid,
        input  cmd_valid, cmd_code, params,
        input  nparams, err, state
    );

    modport slave (
        input  in, in_valid,
        output cmd_valid, cmd_code, params,
        output nparams, err, state
    );
endinterface

// File: rtl/csi_param_acc.sv
// One decimal parameter slot: saturating value*10+digit
// plus a flag recording that at least one digit arrived.
module csi_param_acc #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          _rst,
    input  logic          i_clr,
    input  logic          i_inc,
    input  logic [3:0]    i_digit,
    output logic [PW-1:0] o_val,
    output logic          o_present
);
    logic [PW-1:0] r_val;
    logic          r_present;
    logic [PW+3:0] w_next;
    logic [PW-1:0] w_sat;

    assign w_next = {4'b0, r_val} * (PW+4)'(10)
                  + {{PW{1'b0}}, i_digit};
    assign w_sat  = (w_next[PW+3:PW] != 4'b0) ? '1
                                              : w_next[PW-1:0];

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_val     <= '0;
            r_present <= 1'b0;
        end else if (i_clr) begin
            r_val     <= '0;
            r_present <= 1'b0;
        end else if (i_inc) begin
            r_val     <= w_sat;
            r_present <= 1'b1;
        end
    end

    assign o_val     = r_val;
    assign o_present = r_present;
endmodule

// File: rtl/csi_decoder.sv
// ANSI CSI escape-sequence decoder with registered command outputs.
// Define CSI_TEXT_CMD_EN to add "clear"/"uname -a" word commands.
module csi_decoder
    import csi_pkg::*;
#(
    parameter int NPARAM = 2,
    parameter int PW     = 8
) (
    input logic          clk,
    input logic          _rst,
    csi_decoder_if.slave bus
);
    logic [7:0] w_b;
    logic       w_v;
    logic       w_dig;
    logic       w_fin;
    logic       w_clr;

    assign w_b   = bus.in;
    assign w_v   = bus.in_valid;
    assign w_dig = (w_b >= 8'h30) && (w_b <= 8'h39);
    assign w_fin = (w_b >= 8'h40) && (w_b <= 8'h7E);

    state_e               r_state;
    logic [2:0]           r_slot;
    logic                 r_cmd_valid;
    logic                 r_err;
    cmd_e                 r_cmd;
    logic [NPARAM*PW-1:0] r_params;
    logic [2:0]           r_n;

`ifdef CSI_TEXT_CMD_EN
    logic [63:0] r_buf;
    logic [3:0]  r_tlen;
    logic        w_print;
    assign w_print = (w_b >= 8'h20) && (w_b <= 8'h7E);
`endif

    assign w_clr = w_v && (r_state == ST_ESC) && (w_b == B_CSI);

    logic [PW-1:0]     w_val [NPARAM];
    logic [NPARAM-1:0] w_pres;

    for (genvar g = 0; g < NPARAM; g++) begin : g_acc
        csi_param_acc #(.PW(PW)) u_acc (
            .clk       (clk),
            ._rst      (_rst),
            .i_clr     (w_clr),
            .i_inc     (w_v && (r_state == ST_CSI) && w_dig
                        && (r_slot == 3'(g))),
            .i_digit   (w_b[3:0]),
            .o_val     (w_val[g]),
            .o_present (w_pres[g])
        );
    end

    cmd_e                 w_cmd;
    logic                 w_one;
    logic [NPARAM*PW-1:0] w_params;
    logic [2:0]           w_cnt;

    // Omitted slots take the command's default, present ones keep their value.
    always_comb begin
        w_cmd    = final_cmd(w_b, w_val[0] == PW'(3));
        w_one    = dflt_one(w_cmd);
        w_params = '0;
        w_cnt    = '0;
        for (int i = 0; i < NPARAM; i++) begin
            w_params[i*PW +: PW] = w_pres[i] ? w_val[i] : PW'(w_one);
            w_cnt = w_cnt + 3'(w_pres[i]);
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_state     <= ST_IDLE;
            r_slot      <= '0;
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b0;
            r_cmd       <= CMD_NONE;
            r_params    <= '0;
            r_n         <= '0;
`ifdef CSI_TEXT_CMD_EN
            r_buf       <= '0;
            r_tlen      <= '0;
`endif
        end else begin
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b0;
            if (w_v) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_b == B_ESC) begin
                            r_state <= ST_ESC;
`ifdef CSI_TEXT_CMD_EN
                        end else if (w_print) begin
                            r_state <= ST_TEXT;
                            r_buf   <= {56'b0, w_b};
                            r_tlen  <= 4'd1;
`endif
                        end
                    end
                    ST_ESC: begin
                        if (w_b == B_CSI) begin
                            r_state <= ST_CSI;
                            r_slot  <= '0;
                        end else if (w_b != B_ESC) begin
                            r_state <= ST_IDLE;
                            r_err   <= 1'b1;
                        end
                    end
                    ST_CSI: begin
                        if (w_dig) begin
                            r_state <= ST_CSI;
                        end else if (w_b == B_SEP) begin
                            // slot NPARAM acts as a discard bucket
                            if (r_slot < 3'(NPARAM))
                                r_slot <= r_slot + 3'd1;
                        end else if (w_fin) begin
                            r_state     <= ST_IDLE;
                            r_cmd_valid <= 1'b1;
                            r_cmd       <= w_cmd;
                            r_params    <= w_params;
                            r_n         <= w_cnt;
                        end else if (w_b == B_ESC) begin
                            r_state <= ST_ESC;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_err   <= 1'b1;
                        end
                    end
`ifdef CSI_TEXT_CMD_EN
                    ST_TEXT: begin
                        if (w_b == B_ESC) begin
                            r_state <= ST_ESC;
                        end else if (w_b == 8'h00 || w_b == 8'h0D) begin
                            r_state <= ST_IDLE;
                            if (r_tlen == 4'd5
                                && r_buf[39:0] == TXT_CLEAR) begin
                                r_cmd_valid <= 1'b1;
                                r_cmd       <= CMD_CLEAR;
                                r_params    <= '0;
                                r_n         <= '0;
                            end else if (r_tlen == 4'd8
                                         && r_buf == TXT_UNAME) begin
                                r_cmd_valid <= 1'b1;
                                r_cmd       <= CMD_UNAME;
                                r_params    <= '0;
                                r_n         <= '0;
                            end
                        end else if (r_tlen == 4'd8) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_buf  <= {r_buf[55:0], w_b};
                            r_tlen <= r_tlen + 4'd1;
                        end
                    end
`endif
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_code  = r_cmd;
    assign bus.params    = r_params;
    assign bus.nparams   = r_n;
    assign bus.err       = r_err;
    assign bus.state     = r_state;
endmodule

// File: tb/tb_csi_decoder.sv
// Bench for csi_decoder: sequence-level reference model checked
// every cycle, plus literal expectations for directed sequences.
module tb_csi_decoder;
    import csi_pkg::*;

    localparam int NP = 2;
    localparam int PW = 8;
    localparam int MAXV = (1 << PW) - 1;
`ifdef CSI_TEXT_CMD_EN
    localparam bit TXT = 1'b1;
`else
    localparam bit TXT = 1'b0;
`endif

    logic clk  = 1'b0;
    logic _rst = 1'b0;
    always #5 clk = ~clk;

    csi_decoder_if #(.NPARAM(NP), .PW(PW)) bus ();

    csi_decoder #(.NPARAM(NP), .PW(PW)) dut (
        .clk  (clk),
        ._rst (_rst),
        .bus  (bus)
    );

    int nvec  = 0;
    int nfail = 0;
    int n_cmd = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0;
    localparam int M_ESC  = 1;
    localparam int M_CSI  = 2;
    localparam int M_TEXT = 3;

    int             mode;
    logic [7:0]     q[$];
    bit             m_cv;
    bit             m_err;
    cmd_e           m_code;
    logic [NP*PW-1:0] m_par;
    int             m_n;

    task automatic decode(input logic [7:0] fin);
        int   v[4];
        bit   p[4];
        int   slot;
        cmd_e code;
        bit   one;
        slot = 0;
        for (int i = 0; i < 4; i++) begin
            v[i] = 0;
            p[i] = 0;
        end
        foreach (q[i]) begin
            if (q[i] == ";") slot++;
            else if (slot < NP) begin
                v[slot] = v[slot] * 10 + (int'(q[i]) - 48);
                if (v[slot] > MAXV) v[slot] = MAXV;
                p[slot] = 1;
            end
        end
        case (fin)
            "A": code = CMD_CUU;
            "B": code = CMD_CUD;
            "C": code = CMD_CUF;
            "D": code = CMD_CUB;
            "E": code = CMD_CNL;
            "F": code = CMD_CPL;
            "G": code = CMD_CHA;
            "H": code = CMD_CUP;
            "J": code = CMD_ED;
            "K": code = CMD_EL;
            "S": code = CMD_SU;
            "T": code = CMD_SD;
            "f": code = CMD_HVP;
            "s": code = CMD_SCP;
            "u": code = CMD_RCP;
            "~": code = (v[0] == 3) ? CMD_DEL : CMD_UNKNOWN;
            default: code = CMD_UNKNOWN;
        endcase
        one = code inside {CMD_CUU, CMD_CUD, CMD_CUF, CMD_CUB,
                           CMD_CNL, CMD_CPL, CMD_CHA, CMD_CUP,
                           CMD_HVP, CMD_SU, CMD_SD};
        m_par = '0;
        m_n   = 0;
        for (int i = 0; i < NP; i++) begin
            m_par[i*PW +: PW] = p[i] ? PW'(v[i]) : PW'(one);
            m_n += int'(p[i]);
        end
        m_cv   = 1;
        m_code = code;
    endtask

    task automatic text_done();
        string s;
        s = "";
        foreach (q[i]) s = $sformatf("%s%c", s, q[i]);
        if (s == "clear" || s == "uname -a") begin
            m_cv   = 1;
            m_code = (s == "clear") ? CMD_CLEAR : CMD_UNAME;
            m_par  = '0;
            m_n    = 0;
        end
    endtask

    task automatic mbyte(input logic [7:0] b);
        bit dig, fin, prn;
        dig = (b >= "0") && (b <= "9");
        fin = (b >= 8'h40) && (b <= 8'h7E);
        prn = (b >= 8'h20) && (b <= 8'h7E);
        case (mode)
            M_IDLE: begin
                if (b == 8'h1B) mode = M_ESC;
                else if (TXT && prn) begin
                    mode = M_TEXT;
                    q.delete();
                    q.push_back(b);
                end
            end
            M_ESC: begin
                if (b == "[") begin
                    mode = M_CSI;
                    q.delete();
                end else if (b != 8'h1B) begin
                    mode  = M_IDLE;
                    m_err = 1;
                end
            end
            M_CSI: begin
                if (dig || b == ";") q.push_back(b);
                else if (fin) begin
                    decode(b);
                    mode = M_IDLE;
                end else if (b == 8'h1B) begin
                    mode  = M_ESC;
                    m_err = 1;
                end else begin
                    mode  = M_IDLE;
                    m_err = 1;
                end
            end
            default: begin
                if (b == 8'h1B) mode = M_ESC;
                else if (b == 8'h00 || b == 8'h0D) begin
                    text_done();
                    mode = M_IDLE;
                end else if (q.size() == 8) mode = M_IDLE;
                else q.push_back(b);
            end
        endcase
    endtask

    always @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            mode   = M_IDLE;
            q.delete();
            m_cv   = 0;
            m_err  = 0;
            m_code = CMD_NONE;
            m_par  = '0;
            m_n    = 0;
        end else begin
            m_cv  = 0;
            m_err = 0;
            if (bus.in_valid) mbyte(bus.in);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("cmd_valid", 64'(bus.cmd_valid), 64'(m_cv));
        chk("err", 64'(bus.err), 64'(m_err));
        chk("cmd_code", 64'(bus.cmd_code), 64'(m_code));
        chk("params", 64'(bus.params), 64'(m_par));
        chk("nparams", 64'(bus.nparams), 64'(m_n));
        if (bus.cmd_valid) n_cmd++;
        if (bus.err) n_err++;
    end

    // ---------------- stimulus ----------------
    task automatic put(input logic [7:0] b);
        @(negedge clk);
        bus.in       = b;
        bus.in_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    // '^' in s stands for ESC; term < 0 means no terminator byte
    task automatic run(input string nm, input string s,
                       input int term, input int gap,
                       input int ec, input int ee,
                       input cmd_e code, input logic [15:0] par,
                       input int n);
        logic [7:0] c;
        n_cmd = 0;
        n_err = 0;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c == "^") c = 8'h1B;
            put(c);
            if (gap > 0) idle(gap);
        end
        if (term >= 0) put(8'(term));
        idle(3);
        #1;
        chk({nm, ".ncmd"}, 64'(n_cmd), 64'(ec));
        chk({nm, ".nerr"}, 64'(n_err), 64'(ee));
        chk({nm, ".code"}, 64'(bus.cmd_code), 64'(code));
        chk({nm, ".params"}, 64'(bus.params), 64'(par));
        chk({nm, ".nparams"}, 64'(bus.nparams), 64'(n));
    endtask

    initial begin
        bus.in       = 8'h00;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.state", 64'(bus.state), 64'd0);
        chk("rst.code", 64'(bus.cmd_code), 64'(CMD_NONE));
        chk("rst.params", 64'(bus.params), 64'd0);
        chk("rst.nparams", 64'(bus.nparams), 64'd0);
        chk("rst.cv", 64'(bus.cmd_valid), 64'd0);
        chk("rst.err", 64'(bus.err), 64'd0);
        @(posedge clk);
        #2 _rst = 1'b1;

        run("del", "^[3~", -1, 0, 1, 0, CMD_DEL, 16'h0003, 1);
        run("cup2", "^[12;45H", -1, 0, 1, 0, CMD_CUP, 16'h2D0C, 2);
        run("cup0", "^[H", -1, 0, 1, 0, CMD_CUP, 16'h0101, 0);
        run("cufsat", "^[999C", -1, 0, 1, 0, CMD_CUF, 16'h01FF, 1);
        run("ed", "^[J", -1, 0, 1, 0, CMD_ED, 16'h0000, 0);
        run("restart", "^[1^[D", -1, 0, 1, 1, CMD_CUB, 16'h0101, 0);
        run("gap", "^[A", -1, 5, 1, 0, CMD_CUU, 16'h0101, 0);
        run("extra", "^[1;2;3A", -1, 0, 1, 0, CMD_CUU, 16'h0201, 2);
        run("tilde2", "^[2~", -1, 0, 1, 0, CMD_UNKNOWN, 16'h0002, 1);
        run("escbad", "^x", -1, 0, 0, 1, CMD_UNKNOWN, 16'h0002, 1);
        run("csibad", "^[1:", -1, 0, 0, 1, CMD_UNKNOWN, 16'h0002, 1);
        run("hvp", "^[5;f", -1, 0, 1, 0, CMD_HVP, 16'h0105, 1);
`ifdef CSI_TEXT_CMD_EN
        run("clear", "clear", 0, 0, 1, 0, CMD_CLEAR, 16'h0000, 0);
        run("uname", "uname -a", 0, 0, 1, 0, CMD_UNAME, 16'h0000, 0);
        run("clean", "clean", 0, 0, 0, 0, CMD_UNAME, 16'h0000, 0);
        run("long", "abcdefghi", 0, 0, 0, 0, CMD_UNAME, 16'h0000, 0);
`else
        run("clear", "clear", 0, 0, 0, 0, CMD_HVP, 16'h0105, 1);
        run("uname", "uname -a", 0, 0, 0, 0, CMD_HVP, 16'h0105, 1);
        run("clean", "clean", 0, 0, 0, 0, CMD_HVP, 16'h0105, 1);
        run("long", "abcdefghi", 0, 0, 0, 0, CMD_HVP, 16'h0105, 1);
`endif

        n_cmd = 0;
        n_err = 0;
        put(8'h1B);
        put(8'h5B);
        put(8'h32);
        @(posedge clk);
        #2;
        _rst         = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("midrst.state", 64'(bus.state), 64'd0);
        chk("midrst.code", 64'(bus.cmd_code), 64'(CMD_NONE));
        chk("midrst.params", 64'(bus.params), 64'd0);
        idle(2);
        @(posedge clk);
        #2 _rst = 1'b1;
        #1;
        chk("midrst.ncmd", 64'(n_cmd), 64'd0);
        chk("midrst.nerr", 64'(n_err), 64'd0);
        run("after", "^[A", -1, 0, 1, 0, CMD_CUU, 16'h0101, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nfail);
        $finish;
    end
endmodule
